rv32_wb_arbiter: RTL and testbench

//   Write-side master of the register file's single write port. Merges in-order pipeline

---
 rtl/rv32_wb_pkg.sv | 22 ++
 rtl/rv32_wb_fifo.sv | 72 +++++++
 rtl/rv32_wb_arbiter.sv | 117 +++++++++++
 tb/tb_rv32_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_wb_pkg.sv
// Shared types and constants for the RV32 write-back arbitration slice.
package rv32_wb_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [31:0]       value;
  } wb_entry_t;

  // Single-bit mask selecting register r; register 0 never yields a bit.
  function automatic logic [REG_COUNT-1:0] reg_mask(input logic [REG_AW-1:0] r);
    logic [REG_COUNT-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rv32_wb_fifo.sv
// Small FIFO holding long-latency unit results until the register-file
// write port is free. Head is visible combinationally; pop consumes it.
module rv32_wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  wb_entry_t i_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Owner of the register file's single write port. The in-order pipeline
// always wins; long-latency results queue in a FIFO and drain in idle
// pipeline cycles. A busy scoreboard of outstanding long-op destinations
// drives the decode hazard stall.
module rv32_wb_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        writeback_flush_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic        pipe_rd_write_in,
  input  logic [31:0] pipe_rd_value_in,
  input  logic        lu_valid_in,
  output logic        lu_ready_out,
  input  logic [4:0]  lu_rd_in,
  input  logic [31:0] lu_value_in,
  input  logic        lu_issue_in,
  input  logic [4:0]  lu_issue_rd_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  dec_rd_in,
  input  logic        dec_rd_write_in,
  output logic        hazard_stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out
);

  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_busy_next;

  wb_entry_t w_lu_entry;
  wb_entry_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_pw;
  logic      w_issue_set;

  // A squashed result or a write to x0 does not claim the port.
  assign w_pw = pipe_rd_write_in & ~writeback_flush_in & (|pipe_rd_in);

  // Ready depends only on occupancy so there is no path from the pop decision.
  assign lu_ready_out = ~w_full;

  // Results for x0 are acknowledged but never queued.
  assign w_push     = lu_valid_in & lu_ready_out & (|lu_rd_in);
  assign w_pop      = ~w_pw & ~w_empty;
  assign w_lu_entry = '{rd: lu_rd_in, value: lu_value_in};

  rv32_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_lu_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write-port mux: pipeline first, then the FIFO head, otherwise quiet zeros.
  always_comb begin
    rd_write_out = 1'b0;
    rd_out       = '0;
    rd_value_out = '0;
    if (w_pw) begin
      rd_write_out = 1'b1;
      rd_out       = pipe_rd_in;
      rd_value_out = pipe_rd_value_in;
    end else if (!w_empty) begin
      rd_write_out = 1'b1;
      rd_out       = w_head.rd;
      rd_value_out = w_head.value;
    end
  end

  // Any source or destination touching an outstanding long-op register stalls decode.
  always_comb begin
    hazard_stall_out = r_busy[rs1_in]
                     | r_busy[rs2_in]
                     | (dec_rd_write_in & r_busy[dec_rd_in])
                     | (lu_issue_in & r_busy[lu_issue_rd_in]);
  end

  // Only an issue that actually leaves decode marks its destination busy.
  assign w_issue_set = lu_issue_in & ~stall_in & ~hazard_stall_out & (|lu_issue_rd_in);

  // Clear on the pop that writes the register, then apply set so set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) begin
      w_busy_next = w_busy_next & ~reg_mask(w_head.rd);
    end
    if (w_issue_set) begin
      w_busy_next = w_busy_next | reg_mask(lu_issue_rd_in);
    end
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register; reset drops all outstanding long ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
module tb_rv32_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        writeback_flush_in;
  logic [4:0]  pipe_rd_in;
  logic        pipe_rd_write_in;
  logic [31:0] pipe_rd_value_in;
  logic        lu_valid_in;
  logic        lu_ready_out;
  logic [4:0]  lu_rd_in;
  logic [31:0] lu_value_in;
  logic        lu_issue_in;
  logic [4:0]  lu_issue_rd_in;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic [4:0]  dec_rd_in;
  logic        dec_rd_write_in;
  logic        hazard_stall_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;

  rv32_wb_arbiter #(.DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_in           (stall_in),
    .writeback_flush_in (writeback_flush_in),
    .pipe_rd_in         (pipe_rd_in),
    .pipe_rd_write_in   (pipe_rd_write_in),
    .pipe_rd_value_in   (pipe_rd_value_in),
    .lu_valid_in        (lu_valid_in),
    .lu_ready_out       (lu_ready_out),
    .lu_rd_in           (lu_rd_in),
    .lu_value_in        (lu_value_in),
    .lu_issue_in        (lu_issue_in),
    .lu_issue_rd_in     (lu_issue_rd_in),
    .rs1_in             (rs1_in),
    .rs2_in             (rs2_in),
    .dec_rd_in          (dec_rd_in),
    .dec_rd_write_in    (dec_rd_write_in),
    .hazard_stall_out   (hazard_stall_out),
    .rd_out             (rd_out),
    .rd_write_out       (rd_write_out),
    .rd_value_out       (rd_value_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pval;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] luval;
    logic        iss;
    logic [4:0]  issrd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  drd;
    logic        dw;
    logic        e_ready;
    logic        e_hz;
    logic        e_w;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{rst: 1'b0, stall: 1'b0, flush: 1'b0, pw: 1'b0, prd: 5'd0, pval: 32'd0,
          luv: 1'b0, lurd: 5'd0, luval: 32'd0, iss: 1'b0, issrd: 5'd0,
          rs1: 5'd0, rs2: 5'd0, drd: 5'd0, dw: 1'b0,
          e_ready: 1'b1, e_hz: 1'b0, e_w: 1'b0, e_rd: 5'd0, e_val: 32'd0};
    return v;
  endfunction

  function automatic vec_t wb(input logic pw, input logic [4:0] prd, input logic [31:0] pval,
                              input logic flush, input logic luv, input logic [4:0] lurd,
                              input logic [31:0] luval, input logic er, input logic ew,
                              input logic [4:0] erd, input logic [31:0] eval);
    vec_t v;
    v = idle_vec();
    v.pw = pw; v.prd = prd; v.pval = pval; v.flush = flush;
    v.luv = luv; v.lurd = lurd; v.luval = luval;
    v.e_ready = er; v.e_w = ew; v.e_rd = erd; v.e_val = eval;
    return v;
  endfunction

  function automatic vec_t hz_vec(input logic iss, input logic [4:0] issrd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] drd, input logic dw,
                                  input logic stall, input logic ehz);
    vec_t v;
    v = idle_vec();
    v.iss = iss; v.issrd = issrd; v.rs1 = rs1; v.rs2 = rs2;
    v.drd = drd; v.dw = dw; v.stall = stall; v.e_hz = ehz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    stall_in           = v.stall;
    writeback_flush_in = v.flush;
    pipe_rd_write_in   = v.pw;
    pipe_rd_in         = v.prd;
    pipe_rd_value_in   = v.pval;
    lu_valid_in        = v.luv;
    lu_rd_in           = v.lurd;
    lu_value_in        = v.luval;
    lu_issue_in        = v.iss;
    lu_issue_rd_in     = v.issrd;
    rs1_in             = v.rs1;
    rs2_in             = v.rs2;
    dec_rd_in          = v.drd;
    dec_rd_write_in    = v.dw;
  endtask

  // Drive one cycle, check outputs at the falling edge, then advance past posedge.
  task automatic run(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".lu_ready"},     {31'd0, lu_ready_out},     {31'd0, v.e_ready});
    chk({tag, ".hazard_stall"}, {31'd0, hazard_stall_out}, {31'd0, v.e_hz});
    chk({tag, ".rd_write"},     {31'd0, rd_write_out},     {31'd0, v.e_w});
    chk({tag, ".rd"},           {27'd0, rd_out},           {27'd0, v.e_rd});
    chk({tag, ".rd_value"},     rd_value_out,              v.e_val);
    @(posedge clk);
    #1;
  endtask

  task automatic step_nc(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    v = idle_vec();
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);
    #1;

    // Reset / single LU result / pipe priority and backpressure / flush and x0 handling.
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 0, 0,  0));
    tbl.push_back(wb(0, 0, 0,          0, 1, 5,  32'h1234,   1, 0, 0,  0));
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 1, 5,  32'h1234));
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 0, 0,  0));
    tbl.push_back(wb(1, 3, 32'h33,     0, 1, 10, 32'h100,    1, 1, 3,  32'h33));
    tbl.push_back(wb(1, 3, 32'h34,     0, 1, 11, 32'h101,    1, 1, 3,  32'h34));
    tbl.push_back(wb(1, 3, 32'h35,     0, 1, 12, 32'h102,    0, 1, 3,  32'h35));
    tbl.push_back(wb(0, 0, 0,          0, 1, 12, 32'h102,    0, 1, 10, 32'h100));
    tbl.push_back(wb(0, 0, 0,          0, 1, 12, 32'h102,    1, 1, 11, 32'h101));
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 1, 12, 32'h102));
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 0, 0,  0));
    tbl.push_back(wb(0, 0, 0,          0, 1, 20, 32'h200,    1, 0, 0,  0));
    tbl.push_back(wb(1, 4, 32'h44,     1, 0, 0,  0,          1, 1, 20, 32'h200));
    tbl.push_back(wb(1, 4, 32'h44,     1, 1, 21, 32'h210,    1, 0, 0,  0));
    tbl.push_back(wb(1, 0, 32'h55,     0, 0, 0,  0,          1, 1, 21, 32'h210));
    tbl.push_back(wb(1, 4, 32'h44,     0, 0, 0,  0,          1, 1, 4,  32'h44));
    tbl.push_back(wb(0, 0, 0,          0, 1, 0,  32'h999,    1, 0, 0,  0));
    tbl.push_back(wb(0, 0, 0,          0, 0, 0,  0,          1, 0, 0,  0));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], $sformatf("v%0d", i));
    end

    // Scoreboard: issue x7, observe hazards until its result pops.
    run(hz_vec(1, 7, 0, 0, 0, 0, 0, 0), "t3.issue7");
    run(hz_vec(0, 0, 7, 0, 0, 0, 0, 1), "t3.rs1");
    run(hz_vec(0, 0, 0, 7, 0, 0, 0, 1), "t3.rs2");
    run(hz_vec(0, 0, 0, 0, 7, 1, 0, 1), "t3.dec_rd");
    run(hz_vec(0, 0, 0, 0, 7, 0, 0, 0), "t3.dec_nowrite");
    run(hz_vec(1, 7, 0, 0, 0, 0, 0, 1), "t3.issue_waw");
    run(hz_vec(1, 9, 7, 0, 0, 0, 0, 1), "t3.issue_blocked");
    run(hz_vec(1, 8, 0, 0, 0, 0, 1, 0), "t3.issue_stalled");
    run(hz_vec(0, 0, 9, 8, 0, 0, 0, 0), "t3.not_set");
    run(hz_vec(1, 0, 0, 0, 0, 0, 0, 0), "t3.issue_x0");
    run(hz_vec(0, 0, 0, 0, 0, 1, 0, 0), "t3.x0_never_busy");
    v = hz_vec(0, 0, 7, 0, 0, 0, 0, 1);
    v.luv = 1'b1; v.lurd = 5'd7; v.luval = 32'h777;
    run(v, "t3.lu_return");
    v = hz_vec(0, 0, 7, 0, 0, 0, 0, 1);
    v.e_w = 1'b1; v.e_rd = 5'd7; v.e_val = 32'h777;
    run(v, "t3.pop");
    run(hz_vec(0, 0, 7, 0, 0, 0, 0, 0), "t3.cleared");

    // Reset with FIFO full and x9 busy drops everything.
    v = wb(1, 3, 32'h31, 0, 1, 13, 32'h1300, 1, 1, 3, 32'h31);
    run(v, "t6.fill1");
    v = wb(1, 3, 32'h32, 0, 1, 14, 32'h1400, 1, 1, 3, 32'h32);
    v.iss = 1'b1; v.issrd = 5'd9;
    run(v, "t6.fill2");
    v = wb(1, 3, 32'h33, 0, 0, 0, 0, 0, 1, 3, 32'h33);
    v.rs1 = 5'd9; v.e_hz = 1'b1;
    run(v, "t6.full_busy");
    v = idle_vec();
    v.rst = 1'b1;
    step_nc(v);
    run(hz_vec(0, 0, 9, 0, 0, 0, 0, 0), "t6.after_reset");
    run(idle_vec(), "t6.empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
